// File: rtl/ysyx_22050612_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the latched request record.
package ysyx_22050612_pkg;

  localparam int XLEN  = 64;
  localparam int MASKW = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
  } lsu_req_t;

  // An access must sit on a boundary of its own size within the 8-byte word.
  function automatic logic is_misaligned(input size_e size, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    unique case (size)
      SZ_B: mis = 1'b0;
      SZ_H: mis = off[0];
      SZ_W: mis = |off[1:0];
      SZ_D: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_align.sv
// Combinational byte-lane steering: store data/mask placement and load extract with sign/zero extension.
module ysyx_22050612_lsu_align
  import ysyx_22050612_pkg::*;
(
  input  size_e             size_i,
  input  logic              unsigned_i,
  input  logic [2:0]        off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   store_data_o,
  output logic [MASKW-1:0]  store_mask_o,
  output logic [XLEN-1:0]   load_data_o
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] raw;
  logic            ext;

  assign shamt = {off_i, 3'b000};

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    store_data_o = wdata_i << shamt;
    store_mask_o = '0;
    raw          = rdata_i >> shamt;
    load_data_o  = raw;
    ext          = 1'b0;
    unique case (size_i)
      SZ_B: begin
        store_mask_o = 8'h01 << off_i;
        ext          = ~unsigned_i & raw[7];
        load_data_o  = {{56{ext}}, raw[7:0]};
      end
      SZ_H: begin
        store_mask_o = 8'h03 << off_i;
        ext          = ~unsigned_i & raw[15];
        load_data_o  = {{48{ext}}, raw[15:0]};
      end
      SZ_W: begin
        store_mask_o = 8'h0F << off_i;
        ext          = ~unsigned_i & raw[31];
        load_data_o  = {{32{ext}}, raw[31:0]};
      end
      SZ_D: begin
        store_mask_o = 8'hFF;
        load_data_o  = raw;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: request latch, IDLE->REQ->WAIT->DONE bus FSM and writeback capture.
module ysyx_22050612_lsu
  import ysyx_22050612_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASKW-1:0]  mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);

  lsu_state_e state_q, state_d;
  lsu_req_t   req_q;
  logic       misalign_q;
  logic       wb_we_q;
  logic [4:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            accept;
  logic            req_mis;
  logic            capture;
  logic [XLEN-1:0] store_data;
  logic [MASKW-1:0] store_mask;
  logic [XLEN-1:0] load_data;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign req_mis = is_misaligned(size_e'(req_size), req_addr[2:0]);
  assign capture = (state_q == ST_WAIT) && mem_rvalid;

  ysyx_22050612_lsu_align u_align (
    .size_i       (req_q.size),
    .unsigned_i   (req_q.uns),
    .off_i        (req_q.addr[2:0]),
    .wdata_i      (req_q.wdata),
    .rdata_i      (mem_rdata),
    .store_data_o (store_data),
    .store_mask_o (store_mask),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && !req_mis) state_d = ST_REQ;
      ST_REQ:  if (mem_ready)          state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid)         state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      misalign_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= accept && req_mis;
      if (accept) begin
        req_q <= '{we: req_we, size: size_e'(req_size), uns: req_unsigned,
                   addr: req_addr, wdata: req_wdata, rd: req_rd};
      end
      // Writeback fields change only on completion and otherwise hold their last value.
      if (capture) begin
        wb_we_q   <= !req_q.we && (req_q.rd != 5'd0);
        wb_rd_q   <= req_q.rd;
        wb_data_q <= req_q.we ? '0 : load_data;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_valid = (state_q == ST_REQ);
  assign mem_we    = mem_valid && req_q.we;
  assign mem_addr  = {req_q.addr[XLEN-1:3], 3'b000};
  assign mem_wdata = store_data;
  assign mem_wmask = req_q.we ? store_mask : '0;
  assign wb_valid  = (state_q == ST_DONE);
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Scoreboard bench for the LSU: a driver plays EXU and memory, a negedge monitor checks bus and writeback.
module tb_ysyx_22050612_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        wb_valid, wb_we, misalign;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  ysyx_22050612_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } bus_t;

  typedef struct {
    bit          is_mis;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    longint      cyc;
  } res_t;

  bus_t   bus_q[$];
  res_t   res_q[$];
  longint cycle_cnt = 0;
  int     n_vec = 0;
  int     n_bad = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-granular view of the 8-byte bus word.
  function automatic logic [63:0] model_load(input logic [63:0] d, input int off, input int nb, input bit uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (!uns && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input int off, input int nb);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < nb; i++) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] w, input int off);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8 - off; i++) v[8*(off+i) +: 8] = w[8*i +: 8];
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_mem_valid"}, mem_valid, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_wmask"}, mem_wmask, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_wb_valid"},  wb_valid, 0);
    check({tag, "_wb_we"},     wb_we, 0);
    check({tag, "_wb_rd"},     wb_rd, 0);
    check({tag, "_wb_data"},   wb_data, 0);
    check({tag, "_misalign"},  misalign, 0);
  endtask

  always @(negedge clk) begin : monitor
    res_t r;
    if (!rst) begin
      if (mem_valid) begin
        if (bus_q.size() == 0) check("unexpected_bus_req", 1, 0);
        else begin
          check("mem_addr",  mem_addr,  bus_q[0].addr);
          check("mem_we",    mem_we,    bus_q[0].we);
          check("mem_wmask", mem_wmask, bus_q[0].mask);
          if (bus_q[0].we) check("mem_wdata", mem_wdata, bus_q[0].wdata);
          if (mem_ready) void'(bus_q.pop_front());
        end
      end
      if (wb_valid) begin
        if (res_q.size() == 0 || res_q[0].is_mis) check("unexpected_wb_valid", 1, 0);
        else begin
          r = res_q.pop_front();
          check("wb_we",   wb_we,   r.we);
          check("wb_rd",   wb_rd,   r.rd);
          check("wb_data", wb_data, r.data);
          check("wb_cycle", cycle_cnt, r.cyc);
        end
      end
      if (misalign) begin
        if (res_q.size() == 0 || !res_q[0].is_mis) check("unexpected_misalign", 1, 0);
        else begin
          r = res_q.pop_front();
          check("misalign_cycle", cycle_cnt, r.cyc);
        end
      end
    end
  end

  // One complete op: EXU handshake, then plays the memory with the given ready/response delays.
  task automatic run_op(input bit we, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata, input logic [4:0] rd,
                        input int rdy_dly, input int rv_dly, input bit hold_busy, input bit abort);
    int     guard, off, nb;
    longint acc;
    bus_t   b;
    res_t   r;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_before_op", req_ready, 1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk); #1;
    acc = cycle_cnt - 1;
    off = int'(addr[2:0]);
    nb  = 1 << sz;
    if (off % nb != 0) begin
      r = '{is_mis: 1'b1, we: 1'b0, rd: 5'd0, data: 64'd0, cyc: acc + 1};
      res_q.push_back(r);
      req_valid = 0;
      repeat (2) begin @(posedge clk); #1; end
      return;
    end
    b = '{addr: {addr[63:3], 3'b000}, we: we, mask: we ? model_mask(off, nb) : 8'h00,
          wdata: model_wdata(wdata, off)};
    bus_q.push_back(b);
    if (!abort) begin
      r = '{is_mis: 1'b0, we: !we && (rd != 0), rd: rd,
            data: we ? 64'd0 : model_load(rdata, off, nb, uns), cyc: acc + 3 + rdy_dly + rv_dly};
      res_q.push_back(r);
    end
    if (hold_busy) begin
      req_we = 1; req_size = 2'd3; req_addr = 64'h8000_0F00; req_wdata = $urandom;
    end else req_valid = 0;
    // Responses offered while the request is still pending must be ignored.
    mem_rvalid = 1; mem_rdata = ~rdata;
    for (int i = 0; i < rdy_dly; i++) begin
      mem_ready = 0;
      if (hold_busy) check("req_ready_busy_req", req_ready, 0);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0; mem_rvalid = 0;
    if (abort) begin
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check_reset_outputs("abort");
      mem_rvalid = 1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 0;
      check("wb_valid_after_abort", wb_valid, 0);
      check("req_ready_after_abort", req_ready, 1);
      return;
    end
    for (int i = 0; i < rv_dly; i++) begin
      if (hold_busy) check("req_ready_busy_wait", req_ready, 0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 0;
    if (hold_busy) begin
      check("req_ready_done", req_ready, 0);
      req_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, w, d;
    logic [1:0]  sz;
    int          off;
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_reset_outputs("reset");

    run_op(0, 2'd3, 0, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 5'd5, 0, 0, 0, 0);
    run_op(0, 2'd0, 0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 5'd6, 0, 0, 0, 0);
    run_op(0, 2'd0, 1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 5'd7, 0, 0, 0, 0);
    run_op(1, 2'd1, 0, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 5'd8, 0, 0, 0, 0);
    run_op(0, 2'd2, 0, 64'h8000_0002, 64'd0, 64'd0, 5'd9, 0, 0, 0, 0);
    run_op(0, 2'd2, 0, 64'h8000_0024, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd10, 4, 3, 1, 0);
    run_op(0, 2'd3, 0, 64'h8000_0040, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd11, 1, 0, 0, 1);
    run_op(0, 2'd1, 0, 64'h8000_004E, 64'd0, 64'h8001_0000_0000_0000, 5'd0, 0, 1, 0, 0);

    for (int n = 0; n < 80; n++) begin
      sz  = 2'($urandom_range(0, 3));
      off = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7))
                                        : int'($urandom_range(0, 7)) & ~((1 << sz) - 1);
      a = {32'h8000_0000, 20'($urandom), 9'($urandom), 3'(off)};
      w = {$urandom, $urandom};
      d = {$urandom, $urandom};
      run_op($urandom_range(0, 1), sz, $urandom_range(0, 1), a, w, d, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("bus_queue_drained", bus_q.size(), 0);
    check("result_queue_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
